// File: rtl/rr_stream_mux_pkg.sv
// Shared types and constants for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_stream_mux_if.sv
// Multi-channel input and single output stream bundle for rr_stream_mux.
interface rr_stream_mux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = $clog2(NCH);

  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   in_data;
  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [SELW-1:0]        out_ch;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Grant selection: fixed channel select or rotating-priority search from ptr.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]          req,
  input  logic [$clog2(NCH)-1:0]  ptr,
  input  logic                    mode,
  input  logic [$clog2(NCH)-1:0]  sel,
  output logic                    gnt_valid,
  output logic [$clog2(NCH)-1:0]  gnt_idx
);
  localparam int unsigned SELW = $clog2(NCH);

  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (mode == MODE_FIXED) begin
      // Out-of-range sel simply matches no channel.
      for (int i = 0; i < int'(NCH); i++) begin
        if (sel == SELW'(i) && req[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end else begin
      // Walk downward so the lowest offset from ptr wins.
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % int'(NCH);
        if (req[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SELW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 stream multiplexer with fixed or round-robin channel selection
// and a single registered output stage.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_stream_mux_if.slave bus
);
  localparam int unsigned SELW = $clog2(NCH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic              gnt_valid;
  logic [SELW-1:0]   gnt_idx;
  logic              load_en;
  logic              xfer;
  logic [NCH-1:0]    in_ready_c;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .mode      (bus.mode),
    .sel       (bus.sel),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state, datapath load and ready generation.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ch_d       = ch_q;
    ptr_d      = ptr_q;
    in_ready_c = '0;
    load_en    = (state_q == EMPTY) || bus.out_ready;
    xfer       = load_en && gnt_valid && rst_n;
    if (xfer) begin
      in_ready_c = NCH'(1) << gnt_idx;
      state_d    = FULL;
      data_d     = bus.in_data[int'(gnt_idx) * int'(WIDTH) +: WIDTH];
      ch_d       = gnt_idx;
      if (bus.mode == MODE_RR) begin
        ptr_d = SELW'((int'(gnt_idx) + 1) % int'(NCH));
      end
    end else if (state_q == FULL && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench for rr_stream_mux (NCH=4, WIDTH=8).
module tb_rr_stream_mux;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  rr_stream_mux_if #(.WIDTH(8), .NCH(4)) bus ();

  rr_stream_mux #(.WIDTH(8), .NCH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] v);
    bus.in_data[c*8 +: 8] = v;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] sel_val;
    logic [3:0] oh;
    int         e;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 8'hA0 + 8'(c));

    // Reset state, including ready suppression with valid inputs present.
    tick();
    tick();
    chk("rst in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst out_data", 32'(bus.out_data), 32'h0);
    chk("rst out_ch", 32'(bus.out_ch), 32'h0);
    bus.in_valid = 4'b0000;
    rst_n = 1'b1;
    tick();

    // Fixed select of channel 2.
    bus.sel = 2'd2;
    bus.in_valid = 4'b1111;
    settle();
    chk("fix in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk("fix out_valid", 32'(bus.out_valid), 32'h1);
    chk("fix out_data", 32'(bus.out_data), 32'hA2);
    chk("fix out_ch", 32'(bus.out_ch), 32'h2);

    // Round-robin fairness, back-to-back with no idle cycles.
    bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e  = i % 4;
      oh = 4'b0001 << e;
      settle();
      chk("rr in_ready", 32'(bus.in_ready), 32'(oh));
      tick();
      chk("rr out_valid", 32'(bus.out_valid), 32'h1);
      chk("rr out_ch", 32'(bus.out_ch), 32'(e));
      chk("rr out_data", 32'(bus.out_data), 32'(8'hA0 + 8'(e)));
    end

    // Round-robin skip: move ptr to 1, then only channels 0 and 3 request.
    bus.in_valid = 4'b0001;
    tick();
    chk("skip pre ch", 32'(bus.out_ch), 32'h0);
    bus.in_valid = 4'b1001;
    settle();
    chk("skip in_ready3", 32'(bus.in_ready), 32'h8);
    tick();
    chk("skip out_ch3", 32'(bus.out_ch), 32'h3);
    chk("skip out_data3", 32'(bus.out_data), 32'hA3);
    settle();
    chk("skip in_ready0", 32'(bus.in_ready), 32'h1);
    tick();
    chk("skip out_ch0", 32'(bus.out_ch), 32'h0);

    // Backpressure hold; sel change during the hold only affects the next grant.
    bus.mode = 1'b0;
    bus.sel = 2'd1;
    bus.in_valid = 4'b0010;
    set_ch(1, 8'h5A);
    tick();
    chk("bp load", 32'(bus.out_data), 32'h5A);
    bus.out_ready = 1'b0;
    set_ch(1, 8'h77);
    set_ch(3, 8'h33);
    bus.sel = 2'd3;
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      chk("bp out_valid", 32'(bus.out_valid), 32'h1);
      chk("bp out_data", 32'(bus.out_data), 32'h5A);
      chk("bp out_ch", 32'(bus.out_ch), 32'h1);
    end
    bus.out_ready = 1'b1;
    settle();
    chk("bp release ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk("bp next data", 32'(bus.out_data), 32'h33);
    chk("bp next ch", 32'(bus.out_ch), 32'h3);

    // Drain to EMPTY, then load from EMPTY while out_ready is low.
    bus.in_valid = 4'b0000;
    settle();
    chk("drain in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("drain out_valid", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b0;
    bus.sel = 2'd0;
    set_ch(0, 8'hA0);
    bus.in_valid = 4'b0001;
    settle();
    chk("empty load ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("empty load valid", 32'(bus.out_valid), 32'h1);
    chk("empty load data", 32'(bus.out_data), 32'hA0);
    bus.in_valid = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    chk("empty again", 32'(bus.out_valid), 32'h0);

    // Fixed mode with the selected channel not valid yields no grant.
    bus.sel = 2'd2;
    bus.in_valid = 4'b1011;
    settle();
    chk("nogrant ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("nogrant valid", 32'(bus.out_valid), 32'h0);

    // One-hot and inverted one-hot patterns; only the selected channel may appear.
    bus.in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      for (int inv = 0; inv < 2; inv++) begin
        for (int b = 0; b < 8; b++) begin
          pat = 8'h01 << b;
          sel_val = (inv == 0) ? pat : ~pat;
          for (int c = 0; c < 4; c++) set_ch(c, (c == s) ? sel_val : ~sel_val);
          tick();
          chk($sformatf("exh s%0d i%0d b%0d", s, inv, b), 32'(bus.out_data), 32'(sel_val));
        end
      end
      chk($sformatf("exh ch s%0d", s), 32'(bus.out_ch), 32'(s));
    end

    // Reset mid-operation: make ptr nonzero, hold 8'hFF, then reset.
    bus.mode = 1'b1;
    bus.in_valid = 4'b0010;
    for (int c = 0; c < 4; c++) set_ch(c, 8'hA0 + 8'(c));
    tick();
    chk("pre rst ch", 32'(bus.out_ch), 32'h1);
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    set_ch(0, 8'hFF);
    bus.in_valid = 4'b0001;
    tick();
    chk("pre rst data", 32'(bus.out_data), 32'hFF);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(bus.out_valid), 32'h0);
    chk("mid rst data", 32'(bus.out_data), 32'h0);
    chk("mid rst ready", 32'(bus.in_ready), 32'h0);
    tick();
    #2;
    rst_n = 1'b1;
    bus.mode = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 8'hA0 + 8'(c));
    settle();
    chk("post rst valid", 32'(bus.out_valid), 32'h0);
    chk("post rst ptr", 32'(bus.in_ready), 32'h1);
    tick();
    chk("post rst ch", 32'(bus.out_ch), 32'h0);
    chk("post rst data", 32'(bus.out_data), 32'hA0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter: WIDTH, default 8, data width per channel in bits (>=1).
REQ-002 Parameter: NCH, default 4, number of input channels (2..16).
REQ-003 Derived constant: SELW = $clog2(NCH); not overridable.
REQ-004 Port: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: mode  input  1  0 = fixed select, 1 = round-robin.
REQ-007 Port: sel  input  SELW  channel index used when mode=0.
REQ-008 Port: in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port: in_valid  input  NCH  per-channel valid.
REQ-010 Port: in_ready  output  NCH  per-channel ready, one-hot or zero.
REQ-011 Port: out_data  output  WIDTH  registered output word.
REQ-012 Port: out_valid  output  1  output register holds a word.
REQ-013 Port: out_ready  input  1  downstream accepts the word.
REQ-014 Port: out_ch  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 The block SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en = EMPTY or (FULL and out_ready); a word SHALL be loaded only when load_en=1 and a grant exists.
REQ-017 Fixed mode: grant = sel when in_valid[sel]=1; otherwise there SHALL be no grant.
REQ-018 Fixed mode: a sel value >= NCH SHALL produce no grant and SHALL NOT be flagged as an error.
REQ-019 Round-robin mode: grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., ptr+NCH-1 modulo NCH.
REQ-020 in_ready[g] SHALL be 1 only for the granted channel g, and only while load_en=1; all other bits SHALL be 0. in_ready is combinational from the current state and inputs.
REQ-021 Transfer on an input channel SHALL occur when in_valid[i] and in_ready[i] are both 1; out_data/out_ch SHALL take that word and index on the same edge.
REQ-022 Latency SHALL be 1 cycle from input transfer to out_valid=1; sustained throughput SHALL be 1 word/cycle when out_ready=1.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_ch SHALL be held stable and in_ready SHALL be all 0.
REQ-024 FULL with out_ready=1 and no grant SHALL go to EMPTY; FULL with out_ready=1 and a grant SHALL stay FULL with the new word (no bubble).
REQ-025 ptr SHALL update to (g+1) mod NCH on every transfer in round-robin mode, and SHALL be unchanged in fixed mode.
REQ-026 A mode or sel change SHALL affect only the next grant; a held word SHALL be unaffected.
REQ-027 in_data of non-granted channels SHALL never reach out_data.

Reset
REQ-028 On rst_n=0, regardless of clk: FSM -> EMPTY, out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-029 in_ready SHALL be all 0 while rst_n=0.
REQ-030 A word held at reset assertion SHALL be discarded; operation SHALL resume on the first clk edge after rst_n rises.

Structure
REQ-031 Package rr_stream_mux_pkg SHALL hold the FSM state enum (EMPTY, FULL) and the mode encoding constants (MODE_FIXED=0, MODE_RR=1).
REQ-032 Grant selection SHALL live in sub-module rr_arbiter (parameter NCH; inputs req, ptr, mode, sel; outputs gnt_valid, gnt_idx); the datapath register SHALL stay in the top module.

Verification (NCH=4, WIDTH=8)
REQ-033 Fixed: mode=0, sel=2, in_valid=4'b1111, in_data ch0..3 = 8'hA0..8'hA3, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA2, out_ch=2.
REQ-034 RR fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no idle cycles.
REQ-035 RR skip: mode=1, ptr=1, in_valid=4'b1001 -> grant ch3, then ptr=0 and grant ch0.
REQ-036 Backpressure: out_valid=1, out_data=8'h5A, out_ready=0 for 3 cycles -> out_data held at 8'h5A, in_ready=0; on out_ready=1, the next word loads in the same cycle.
REQ-037 Exhaustive fault check: for each sel 0..3, drive one-hot and inverted one-hot 1-bit patterns on channels -> out_data equals the selected channel every time.
REQ-038 Reset mid-operation: assert rst_n=0 while FULL with 8'hFF held -> out_valid=0 and out_data=0 immediately, ptr=0 after release.
